// File: rtl/cpu_bus_port.sv
// CPU-side endpoint of the 8-bit bus handshake.
// Turns core load/store requests into CPUsent/CPUreceived strobes with timeout.
module cpu_bus_port #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_req,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic [7:0] BusInput,
  output logic       CPUsent,
  output logic       CPUreceived,
  input  logic [7:0] BusData,
  input  logic       Busreceived,
  input  logic       Bussent
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_SEND = 3'd1,
    WR_ACK  = 3'd2,
    WR_REL  = 3'd3,
    RD_WAIT = 3'd4
  } state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tmo;
  logic       waiting;

  logic [7:0] bus_in_q, bus_in_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       sent_q, sent_d;
  logic       recv_q, recv_d;
  logic       rdv_q, rdv_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  // The TIMEOUT-th waiting edge without a response aborts.
  assign tmo = (cnt_q == CntLast);
  assign waiting = (state_q == WR_ACK) || (state_q == WR_REL) ||
                   (state_q == RD_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_req)      state_d = WR_SEND;
        else if (rd_req) state_d = RD_WAIT;
      end
      WR_SEND: state_d = WR_ACK;
      WR_ACK: begin
        if (Busreceived) state_d = WR_REL;
        else if (tmo)    state_d = IDLE;
      end
      WR_REL: begin
        if (!Busreceived || tmo) state_d = IDLE;
      end
      RD_WAIT: begin
        if (Bussent || tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = '0;
    if (waiting && state_d == state_q) cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    bus_in_d  = bus_in_q;
    rd_data_d = rd_data_q;
    sent_d    = sent_q;
    recv_d    = recv_q;
    rdv_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          bus_in_d = wr_data;
          sent_d   = 1'b1;
        end else if (rd_req) begin
          recv_d = 1'b0;
        end
      end
      WR_SEND: sent_d = 1'b0;
      WR_ACK: begin
        if (!Busreceived && tmo) begin
          err_d  = 1'b1;
          sent_d = 1'b0;
          recv_d = 1'b1;
        end
      end
      WR_REL: begin
        if (!Busreceived) begin
          done_d = 1'b1;
        end else if (tmo) begin
          err_d  = 1'b1;
          sent_d = 1'b0;
          recv_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (Bussent) begin
          rd_data_d = BusData;
          rdv_d     = 1'b1;
          recv_d    = 1'b1;
        end else if (tmo) begin
          err_d  = 1'b1;
          sent_d = 1'b0;
          recv_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_in_q  <= '0;
      rd_data_q <= '0;
      sent_q    <= 1'b0;
      recv_q    <= 1'b1;
      rdv_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      bus_in_q  <= bus_in_d;
      rd_data_q <= rd_data_d;
      sent_q    <= sent_d;
      recv_q    <= recv_d;
      rdv_q     <= rdv_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign BusInput    = bus_in_q;
  assign rd_data     = rd_data_q;
  assign CPUsent     = sent_q;
  assign CPUreceived = recv_q;
  assign rd_valid    = rdv_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cpu_bus_port.sv
// Bench for cpu_bus_port: directed handshake cases plus random transfers.
// Expected timing is derived per transaction from wait lengths.
module tb_cpu_bus_port;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;
  logic       busy;
  logic [7:0] BusInput;
  logic       CPUsent;
  logic       CPUreceived;
  logic [7:0] BusData;
  logic       Busreceived;
  logic       Bussent;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_bus_in;
  logic [7:0] m_rd;

  always #5 clk = ~clk;

  cpu_bus_port #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .BusInput    (BusInput),
    .CPUsent     (CPUsent),
    .CPUreceived (CPUreceived),
    .BusData     (BusData),
    .Busreceived (Busreceived),
    .Bussent     (Bussent)
  );

  task automatic chk(input string tag, input logic b, input logic dn,
                     input logic er, input logic rv, input logic cs,
                     input logic cr);
    logic [21:0] obs;
    logic [21:0] exp;
    obs = {busy, done, err, rd_valid, CPUsent, CPUreceived,
           BusInput, rd_data};
    exp = {b, dn, er, rv, cs, cr, m_bus_in, m_rd};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      wr_req = 1'b0;
      rd_req = 1'b0;
      Busreceived = 1'b0;
      Bussent = 1'b0;
      @(negedge clk);
      chk(tag, 0, 0, 0, 0, 0, 1);
    end
  endtask

  // a: WR_ACK edge that first sees Busreceived; h: extra high WR_REL edges.
  task automatic run_write(input logic [7:0] d, input int a, input int h,
                           input logic also_rd, input int rst_at,
                           input string tag);
    int  n_out;
    bit  is_err;
    bit  stopped;
    if (a > TO) begin
      n_out = 1 + TO;
      is_err = 1;
    end else if (h + 1 > TO) begin
      n_out = 1 + a + TO;
      is_err = 1;
    end else begin
      n_out = 2 + a + h;
      is_err = 0;
    end
    stopped = 0;
    wr_req = 1'b1;
    wr_data = d;
    rd_req = also_rd;
    Busreceived = 1'b0;
    Bussent = 1'($urandom);
    m_bus_in = d;
    for (int n = 0; n <= n_out && !stopped; n++) begin
      @(negedge clk);
      if (rst_at > 0 && n == rst_at) begin
        m_bus_in = 8'h00;
        m_rd = 8'h00;
        chk({tag, "_rst"}, 0, 0, 0, 0, 0, 1);
        stopped = 1;
      end else begin
        chk(tag, n < n_out, !is_err && n == n_out, is_err && n == n_out,
            0, n == 0, 1);
        wr_req = 1'($urandom);
        rd_req = 1'($urandom);
        wr_data = 8'($urandom);
        Bussent = 1'($urandom);
        Busreceived = (n + 1 >= 1 + a) && (n + 1 <= 1 + a + h);
        if (rst_at > 0 && n + 1 == rst_at) rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    Busreceived = 1'b0;
    Bussent = 1'b0;
  endtask

  // dly: first edge index (0 = accept edge) at which Bussent is high.
  task automatic run_read(input logic [7:0] d, input int dly,
                          input string tag);
    int n_out;
    int cap;
    bit is_err;
    cap = (dly < 1) ? 1 : dly;
    if (cap <= TO) begin
      n_out = cap;
      is_err = 0;
    end else begin
      n_out = TO;
      is_err = 1;
    end
    rd_req = 1'b1;
    wr_req = 1'b0;
    Busreceived = 1'($urandom);
    Bussent = (dly <= 0);
    BusData = (dly <= 0) ? d : 8'($urandom);
    for (int n = 0; n <= n_out; n++) begin
      @(negedge clk);
      if (n == n_out && !is_err) m_rd = d;
      chk(tag, n < n_out, 0, is_err && n == n_out,
          !is_err && n == n_out, 0, !(n < n_out));
      wr_req = 1'($urandom);
      rd_req = 1'($urandom);
      wr_data = 8'($urandom);
      Busreceived = 1'($urandom);
      Bussent = (n + 1 >= dly);
      BusData = (n + 1 >= dly) ? d : 8'($urandom);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    Busreceived = 1'b0;
    Bussent = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    wr_data = 8'hFF;
    BusData = 8'hFF;
    Busreceived = 1'b1;
    Bussent = 1'b1;
    m_bus_in = 8'h00;
    m_rd = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset", 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    idle(1, "post_reset");

    run_write(8'hA5, 1, 2, 0, 0, "wr");
    idle(1, "wr_idle");
    run_read(8'h3C, 2, "rd");
    run_write(8'h11, 1, 2, 1, 0, "wr_rd_both");
    run_read(8'h77, 1000, "rd_timeout");
    run_read(8'h5A, 0, "rd_prehigh");
    run_read(8'h96, 1, "rd_min");
    run_write(8'h01, 16, 0, 0, 0, "wr_ack_edge");
    run_write(8'h02, 17, 0, 0, 0, "wr_ack_to");
    run_write(8'h03, 1, 15, 0, 0, "wr_rel_edge");
    run_write(8'h04, 2, 16, 0, 0, "wr_rel_to");
    run_read(8'hE1, 16, "rd_edge");
    run_read(8'hE2, 17, "rd_to_edge");
    run_write(8'hC3, 10, 0, 0, 3, "wr_rst");
    idle(2, "rst_idle");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        run_write(8'($urandom), $urandom_range(1, 18),
                  $urandom_range(0, 17), 1'($urandom), 0, "rnd_wr");
      else
        run_read(8'($urandom), $urandom_range(0, 18), "rnd_rd");
      idle($urandom_range(0, 2), "rnd_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
